// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the Avalon SRAM arbiter.
// Optional feature macro: SRAM_ARB_PRIORITY_EN (master 0 wins every idle arbitration).
package sram_arb_pkg;

   localparam int NUM_MASTERS_DEF = 3;
   localparam int BURST_MAX_DEF   = 4;
   localparam int MAX_PENDING_DEF = 4;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // Index width that stays legal for single-entry sizes.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// Tag FIFO recording which master owns each outstanding read, in issue order.
// Push and pop in the same cycle both take effect, including when full.
module sram_arb_tag_fifo
   import sram_arb_pkg::*;
#(
   parameter int W     = 2,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = clog2_min1(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     pop_data,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/avalon_sram_arbiter.sv
// Round-robin arbiter sharing one Avalon SRAM slave among NUM_MASTERS requesters.
// Define SRAM_ARB_PRIORITY_EN to give master 0 absolute priority at arbitration.
module avalon_sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_MASTERS = NUM_MASTERS_DEF,
   parameter int BURST_MAX   = BURST_MAX_DEF,
   parameter int MAX_PENDING = MAX_PENDING_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_MASTERS-1:0]       m_read_n,
   input  logic [NUM_MASTERS-1:0]       m_write_n,
   input  logic [NUM_MASTERS-1:0][31:0] m_address,
   input  logic [NUM_MASTERS-1:0][15:0] m_writedata,
   input  logic [NUM_MASTERS-1:0][1:0]  m_byteenable_n,
   output logic [NUM_MASTERS-1:0]       m_waitrequest,
   output logic [NUM_MASTERS-1:0]       m_readdatavalid,
   output logic [15:0]                  m_readdata,
   output logic                         s_read_n,
   output logic                         s_write_n,
   output logic [31:0]                  s_address,
   output logic [15:0]                  s_writedata,
   output logic [1:0]                   s_byteenable_n,
   input  logic                         s_waitrequest,
   input  logic                         s_readdatavalid,
   input  logic [15:0]                  s_readdata,
   output logic [NUM_MASTERS-1:0]       grant,
   output logic                         err_rdv
);

   localparam int IDX_W = clog2_min1(NUM_MASTERS);
   localparam int CNT_W = $clog2(MAX_PENDING + 1);
   localparam int BC_W  = $clog2(BURST_MAX + 1);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]       gidx_q, gidx_d;
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic [BC_W-1:0]        xfer_cnt_q, xfer_cnt_d;
   logic                   err_rdv_q, err_rdv_d;

   logic [NUM_MASTERS-1:0] req;
   logic [IDX_W-1:0]       arb_idx, fifo_tag;
   logic                   in_grant, rd_g, wr_g, req_g, rd_block, accept;
   logic                   fifo_empty, fifo_full, fifo_pop;
   logic [CNT_W-1:0]       fifo_cnt;

   // First requester strictly after 'last'; 'last' itself is checked last.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                                input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] pick;
      int idx;
      pick = last;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_MASTERS;
         if (r[idx]) pick = IDX_W'(idx);
      end
      return pick;
   endfunction

   assign req = ~m_read_n | ~m_write_n;

`ifdef SRAM_ARB_PRIORITY_EN
   assign arb_idx = req[0] ? '0 : rr_pick(req & ~NUM_MASTERS'(1), last_grant_q);
`else
   assign arb_idx = rr_pick(req, last_grant_q);
`endif

   assign in_grant = (state_q == ARB_GRANT);
   assign rd_g     = in_grant && !m_read_n[gidx_q];
   assign wr_g     = in_grant && !m_write_n[gidx_q];
   assign req_g    = rd_g || wr_g;
   assign fifo_pop = s_readdatavalid && !fifo_empty;
   // A return in the same cycle frees a slot, so a full FIFO need not stall then.
   assign rd_block = rd_g && fifo_full && !fifo_pop;
   assign accept   = req_g && !s_waitrequest && !rd_block;

   assign s_read_n       = !(rd_g && !rd_block);
   assign s_write_n      = !(wr_g && !rd_g);
   assign s_address      = in_grant ? m_address[gidx_q]      : '0;
   assign s_writedata    = in_grant ? m_writedata[gidx_q]    : '0;
   assign s_byteenable_n = in_grant ? m_byteenable_n[gidx_q] : '1;
   assign grant          = grant_q;
   assign err_rdv        = err_rdv_q;
   assign m_readdata     = fifo_pop ? s_readdata : '0;

   always_comb begin
      m_waitrequest = '1;
      if (in_grant) m_waitrequest[gidx_q] = s_waitrequest | rd_block;
   end

   always_comb begin
      m_readdatavalid = '0;
      if (fifo_pop) m_readdatavalid[fifo_tag] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      gidx_d       = gidx_q;
      last_grant_d = last_grant_q;
      xfer_cnt_d   = xfer_cnt_q;
      err_rdv_d    = err_rdv_q | (s_readdatavalid && (fifo_cnt == '0));
      case (state_q)
         ARB_IDLE: begin
            if (|req) begin
               state_d          = ARB_GRANT;
               gidx_d           = arb_idx;
               grant_d          = '0;
               grant_d[arb_idx] = 1'b1;
            end
         end
         ARB_GRANT: begin
            if (!req_g || (accept && xfer_cnt_q == BC_W'(BURST_MAX - 1))) begin
               state_d      = ARB_IDLE;
               grant_d      = '0;
               last_grant_d = gidx_q;
               xfer_cnt_d   = '0;
            end else if (accept) begin
               xfer_cnt_d = xfer_cnt_q + BC_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ARB_IDLE;
         grant_q      <= '0;
         gidx_q       <= '0;
         last_grant_q <= IDX_W'(NUM_MASTERS - 1);
         xfer_cnt_q   <= '0;
         err_rdv_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         gidx_q       <= gidx_d;
         last_grant_q <= last_grant_d;
         xfer_cnt_q   <= xfer_cnt_d;
         err_rdv_q    <= err_rdv_d;
      end
   end

   sram_arb_tag_fifo #(
      .W     (IDX_W),
      .DEPTH (MAX_PENDING)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept && rd_g),
      .push_data (gidx_q),
      .pop       (fifo_pop),
      .pop_data  (fifo_tag),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_cnt)
   );

endmodule

// File: tb/tb_avalon_sram_arbiter.sv
// Self-checking bench for avalon_sram_arbiter; read returns are tracked by a tag/data scoreboard.
module tb_avalon_sram_arbiter;

   localparam int NM = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [NM-1:0]       m_read_n, m_write_n;
   logic [NM-1:0][31:0] m_address;
   logic [NM-1:0][15:0] m_writedata;
   logic [NM-1:0][1:0]  m_byteenable_n;
   logic [NM-1:0]       m_waitrequest, m_readdatavalid;
   logic [15:0]         m_readdata;
   logic                s_read_n, s_write_n;
   logic [31:0]         s_address;
   logic [15:0]         s_writedata;
   logic [1:0]          s_byteenable_n;
   logic                s_waitrequest, s_readdatavalid;
   logic [15:0]         s_readdata;
   logic [NM-1:0]       grant;
   logic                err_rdv;

   typedef struct packed {
      logic [1:0]  tag;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   avalon_sram_arbiter #(.NUM_MASTERS(NM), .BURST_MAX(4), .MAX_PENDING(4)) dut (
      .clk(clk), .rst(rst),
      .m_read_n(m_read_n), .m_write_n(m_write_n), .m_address(m_address),
      .m_writedata(m_writedata), .m_byteenable_n(m_byteenable_n),
      .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
      .s_read_n(s_read_n), .s_write_n(s_write_n), .s_address(s_address),
      .s_writedata(s_writedata), .s_byteenable_n(s_byteenable_n),
      .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
      .grant(grant), .err_rdv(err_rdv)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, compared=%0d mismatched=%0d", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      m_read_n        = '1;
      m_write_n       = '1;
      s_waitrequest   = 1'b0;
      s_readdatavalid = 1'b0;
      s_readdata      = '0;
      for (int i = 0; i < NM; i++) begin
         m_address[i]      = 32'h100 * (i + 1);
         m_writedata[i]    = 16'h1100 * 16'(i + 1);
         m_byteenable_n[i] = 2'(i);
      end
   endtask

   // Leaves the bench 1 time unit after a rising edge with reset released.
   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      m_write_n = '0;
      m_read_n  = '0;
      #2;
      n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL reset_grant: got %b want 000", grant); end
      n_cmp++; if (s_read_n !== 1'b1 || s_write_n !== 1'b1) begin n_err++; $display("FAIL reset_sreq: got rd_n=%b wr_n=%b want 1 1", s_read_n, s_write_n); end
      n_cmp++; if (m_waitrequest !== 3'b111) begin n_err++; $display("FAIL reset_wait: got %b want 111", m_waitrequest); end
      n_cmp++; if (err_rdv !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_rdv); end
      n_cmp++; if (m_readdatavalid !== 3'b000) begin n_err++; $display("FAIL reset_rdv: got %b want 000", m_readdatavalid); end
   endtask

   task automatic test_write_rr();
      logic [2:0] first_g, second_g;
      int m0_acc;
      first_g = '0; second_g = '0; m0_acc = 0;
      do_reset();
      m_write_n = 3'b010;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (c == 0) begin
            n_cmp++; if (grant !== 3'b000 || s_write_n !== 1'b1) begin n_err++; $display("FAIL wr_idle0: got grant=%b wr_n=%b want 000 1", grant, s_write_n); end
         end
         if (grant != 3'b000) begin
            if (first_g == 3'b000) first_g = grant;
            else if (grant != first_g && second_g == 3'b000) second_g = grant;
         end
         if (grant == 3'b001 && second_g == 3'b000 && !s_write_n && !s_waitrequest) begin
            m0_acc++;
            n_cmp++;
            if (s_address !== 32'h100 || s_writedata !== 16'h1100 || s_byteenable_n !== 2'd0 || m_waitrequest !== 3'b110) begin
               n_err++;
               $display("FAIL wr_mux: got addr=%h data=%h be=%b wait=%b want 100 1100 00 110", s_address, s_writedata, s_byteenable_n, m_waitrequest);
            end
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (first_g !== 3'b001) begin n_err++; $display("FAIL wr_first_grant: got %b want 001", first_g); end
      n_cmp++; if (m0_acc != 4) begin n_err++; $display("FAIL wr_burst_len: got %0d want 4", m0_acc); end
      n_cmp++; if (second_g !== 3'b100) begin n_err++; $display("FAIL wr_second_grant: got %b want 100", second_g); end
   endtask

   task automatic test_read_burst();
      int issued, slv_cnt, returns;
      int due[$];
      logic [15:0] rdat[$];
      exp_t e;
      logic [2:0] oh;
      issued = 0; slv_cnt = 0; returns = 0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         m_read_n = (issued < 4) ? 3'b101 : 3'b111;
         if (due.size() > 0 && due[0] == c) begin
            s_readdatavalid = 1'b1;
            s_readdata      = rdat.pop_front();
            void'(due.pop_front());
         end else begin
            s_readdatavalid = 1'b0;
            s_readdata      = '0;
         end
         #1;
         if (!m_read_n[1] && !m_waitrequest[1]) begin
            sb.push_back('{tag: 2'd1, data: 16'hA5A5 + 16'(issued)});
            issued++;
         end
         if (!s_read_n && !s_waitrequest) begin
            due.push_back(c + 3);
            rdat.push_back(16'hA5A5 + 16'(slv_cnt));
            slv_cnt++;
         end
         if (s_readdatavalid || m_readdatavalid != 3'b000) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL rd_unexpected: got rdv=%b with empty scoreboard", m_readdatavalid);
            end else begin
               e = sb.pop_front();
               oh = '0; oh[e.tag] = 1'b1;
               returns++;
               if (m_readdatavalid !== oh || m_readdata !== e.data) begin
                  n_err++; $display("FAIL rd_return: got rdv=%b data=%h want %b %h", m_readdatavalid, m_readdata, oh, e.data);
               end
            end
         end else if (m_readdata !== 16'h0) begin
            n_cmp++; n_err++; $display("FAIL rd_data_idle: got %h want 0000", m_readdata);
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (returns != 4 || sb.size() != 0) begin n_err++; $display("FAIL rd_count: got returns=%0d left=%0d want 4 0", returns, sb.size()); end
      n_cmp++; if (err_rdv !== 1'b0) begin n_err++; $display("FAIL rd_err: got %b want 0", err_rdv); end
   endtask

   task automatic test_max_pending();
      int issued, slv_cnt, ret_idx, returns;
      exp_t e;
      logic [2:0] oh;
      issued = 0; slv_cnt = 0; ret_idx = 0; returns = 0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         m_read_n = (issued < 5) ? 3'b110 : 3'b111;
         if (c == 9 || (c >= 12 && c <= 15)) begin
            s_readdatavalid = 1'b1;
            s_readdata      = 16'h1000 + 16'(ret_idx);
            ret_idx++;
         end else begin
            s_readdatavalid = 1'b0;
            s_readdata      = '0;
         end
         #1;
         if (c >= 6 && c <= 8) begin
            n_cmp++;
            if (m_waitrequest[0] !== 1'b1 || s_read_n !== 1'b1 || grant !== 3'b001) begin
               n_err++; $display("FAIL mp_hold c%0d: got wait=%b rd_n=%b grant=%b want 1 1 001", c, m_waitrequest[0], s_read_n, grant);
            end
         end
         if (c == 9) begin
            n_cmp++;
            if (issued != 4 || m_waitrequest[0] !== 1'b0 || s_read_n !== 1'b0) begin
               n_err++; $display("FAIL mp_release: got issued=%0d wait=%b rd_n=%b want 4 0 0", issued, m_waitrequest[0], s_read_n);
            end
         end
         if (!m_read_n[0] && !m_waitrequest[0]) begin
            sb.push_back('{tag: 2'd0, data: 16'h1000 + 16'(issued)});
            issued++;
         end
         if (!s_read_n && !s_waitrequest) slv_cnt++;
         if (s_readdatavalid || m_readdatavalid != 3'b000) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL mp_unexpected: got rdv=%b with empty scoreboard", m_readdatavalid);
            end else begin
               e = sb.pop_front();
               oh = '0; oh[e.tag] = 1'b1;
               returns++;
               if (m_readdatavalid !== oh || m_readdata !== e.data) begin
                  n_err++; $display("FAIL mp_return: got rdv=%b data=%h want %b %h", m_readdatavalid, m_readdata, oh, e.data);
               end
            end
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (issued != 5 || slv_cnt != 5) begin n_err++; $display("FAIL mp_issued: got master=%0d slave=%0d want 5 5", issued, slv_cnt); end
      n_cmp++; if (returns != 5 || sb.size() != 0 || err_rdv !== 1'b0) begin n_err++; $display("FAIL mp_drain: got returns=%0d left=%0d err=%b want 5 0 0", returns, sb.size(), err_rdv); end
   endtask

   task automatic test_err_rdv();
      do_reset();
      #1;
      n_cmp++; if (err_rdv !== 1'b0) begin n_err++; $display("FAIL err_pre: got %b want 0", err_rdv); end
      s_readdatavalid = 1'b1;
      s_readdata      = 16'hBEEF;
      #1;
      n_cmp++; if (m_readdatavalid !== 3'b000 || m_readdata !== 16'h0) begin n_err++; $display("FAIL err_drop: got rdv=%b data=%h want 000 0000", m_readdatavalid, m_readdata); end
      @(posedge clk); #1;
      s_readdatavalid = 1'b0;
      #1;
      n_cmp++; if (err_rdv !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err_rdv); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (err_rdv !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err_rdv); end
   endtask

   task automatic test_reset_mid();
      int issued;
      bit hit;
      issued = 0; hit = 0;
      do_reset();
      m_read_n = 3'b011;
      for (int c = 0; c < 10 && !hit; c++) begin
         #1;
         if (issued == 2) begin
            hit = 1;
            n_cmp++; if (grant !== 3'b100 || err_rdv !== 1'b0) begin n_err++; $display("FAIL rm_pre: got grant=%b err=%b want 100 0", grant, err_rdv); end
            rst = 1'b0;
            #1;
            n_cmp++; if (grant !== 3'b000 || s_read_n !== 1'b1 || m_waitrequest !== 3'b111) begin
               n_err++; $display("FAIL rm_reset: got grant=%b rd_n=%b wait=%b want 000 1 111", grant, s_read_n, m_waitrequest);
            end
         end else begin
            if (!m_read_n[2] && !m_waitrequest[2]) issued++;
            @(posedge clk); #1;
         end
      end
      if (!hit) begin n_cmp++; n_err++; $display("FAIL rm_timeout: got issued=%0d want 2", issued); end
      m_read_n = 3'b111;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         s_readdatavalid = 1'b1;
         s_readdata      = 16'h5A00 + 16'(k);
         #1;
         n_cmp++; if (m_readdatavalid !== 3'b000) begin n_err++; $display("FAIL rm_stale%0d: got rdv=%b want 000", k, m_readdatavalid); end
      end
      @(posedge clk); #1;
      s_readdatavalid = 1'b0;
      #1;
      n_cmp++; if (err_rdv !== 1'b1) begin n_err++; $display("FAIL rm_err: got %b want 1", err_rdv); end
   endtask

   task automatic test_two_masters();
      logic [2:0] got[$];
      logic [2:0] want[3];
      logic [2:0] prev;
`ifdef SRAM_ARB_PRIORITY_EN
      want = '{3'b001, 3'b001, 3'b001};
`else
      want = '{3'b001, 3'b010, 3'b001};
`endif
      do_reset();
      m_write_n = 3'b100;
      prev = '0;
      for (int c = 0; c < 40 && got.size() < 3; c++) begin
         #1;
         if (grant != 3'b000 && prev == 3'b000) got.push_back(grant);
         prev = grant;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (i >= got.size()) begin
            n_err++; $display("FAIL arb%0d: got no grant want %b", i, want[i]);
         end else if (got[i] !== want[i]) begin
            n_err++; $display("FAIL arb%0d: got %b want %b", i, got[i], want[i]);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_write_rr();
      test_read_burst();
      test_max_pending();
      test_err_rdv();
      test_reset_mid();
      test_two_masters();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/avalon_sram_arbiter.md
AVALON_SRAM_ARBITER -- requirements
Module: avalon_sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3: number of Avalon requesters sharing the SRAM slave.
REQ-002 SHALL have parameter BURST_MAX, default 4: maximum accepted transfers per grant before re-arbitration.
REQ-003 SHALL have parameter MAX_PENDING, default 4: maximum outstanding reads awaiting readdatavalid.
REQ-004 SHALL have the following ports, with one clock and an asynchronous, active-low reset:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- m_read_n  in  NUM_MASTERS  per-master read request, active-low.
- m_write_n  in  NUM_MASTERS  per-master write request, active-low.
- m_address  in  NUM_MASTERS x 32  per-master address.
- m_writedata  in  NUM_MASTERS x 16  per-master write data.
- m_byteenable_n  in  NUM_MASTERS x 2  per-master byte enables, active-low.
- m_waitrequest  out  NUM_MASTERS  per-master stall.
- m_readdatavalid  out  NUM_MASTERS  per-master read return strobe.
- m_readdata  out  16  read data, broadcast to all masters.
- s_read_n, s_write_n  out  1 each  slave requests, active-low.
- s_address  out  32  slave address.
- s_writedata  out  16  slave write data.
- s_byteenable_n  out  2  slave byte enables.
- s_waitrequest  in  1  slave stall.
- s_readdatavalid  in  1  slave read return strobe.
- s_readdata  in  16  slave read data.
- grant  out  NUM_MASTERS  one-hot current grant; all zero when idle.
- err_rdv  out  1  sticky: readdatavalid received with no read pending.

Function
REQ-005 SHALL implement a two-state FSM, ARB_IDLE and ARB_GRANT.
REQ-006 A master SHALL be requesting when m_read_n[i]==0 or m_write_n[i]==0.
REQ-007 In ARB_IDLE, if any master is requesting, the FSM SHALL register a grant next cycle to the first requester after last_grant (round-robin, wrapping at NUM_MASTERS-1 to 0) and enter ARB_GRANT.
REQ-008 In ARB_IDLE: s_read_n=s_write_n=1 and every m_waitrequest=1.
REQ-009 In ARB_GRANT, s_address/s_writedata/s_byteenable_n/s_read_n/s_write_n SHALL mux combinationally from the granted master.
REQ-010 In ARB_GRANT, m_waitrequest[g]=s_waitrequest for granted g; every non-granted m_waitrequest=1.
REQ-011 A transfer SHALL be accepted in a cycle where the granted master requests and s_waitrequest==0; read has priority if read_n and write_n are both low.
REQ-012 If a read is requested while the pending count equals MAX_PENDING, the block SHALL force s_read_n=1 and m_waitrequest[g]=1 until a slot frees.
REQ-013 ARB_GRANT SHALL return to ARB_IDLE and set last_grant=g after BURST_MAX accepted transfers, or in any cycle the granted master is not requesting; the transfer counter then clears.
REQ-014 Each accepted read SHALL push g into a tag FIFO of depth MAX_PENDING.
REQ-015 On s_readdatavalid, the block SHALL pop the FIFO, pulse m_readdatavalid[tag] for that cycle, and set m_readdata=s_readdata; m_readdata=0 otherwise.
REQ-016 Simultaneous push and pop SHALL both take effect with the count unchanged.
REQ-017 Read ordering SHALL be preserved; returns may arrive while in ARB_IDLE or under another grant.
REQ-018 s_readdatavalid with an empty tag FIFO SHALL be dropped and SHALL set err_rdv, which stays set until reset.

Reset
REQ-019 On rst low, the block SHALL enter ARB_IDLE with grant=0, last_grant=NUM_MASTERS-1, transfer count 0, tag FIFO empty, err_rdv=0, all m_readdatavalid=0, and s_read_n=s_write_n=1.
REQ-020 Reset mid-operation SHALL discard pending reads; later slave returns SHALL set err_rdv.

Configuration
REQ-021 With SRAM_ARB_PRIORITY_EN defined, master 0 SHALL win every ARB_IDLE arbitration in which it requests, and the remaining masters SHALL be round-robin among themselves.
REQ-022 Without SRAM_ARB_PRIORITY_EN, all masters SHALL be pure round-robin (REQ-007).

Structure
REQ-023 Package sram_arb_pkg SHALL hold the FSM state enum and the default-parameter constants.
REQ-024 The tag FIFO SHALL be sub-module sram_arb_tag_fifo (parameterised width and depth, with push, pop, empty, full and count).

Verification
REQ-025 Masters 0 and 2 write simultaneously from reset, s_waitrequest=0 -> grant=001 first, 4 writes accepted, then grant=100.
REQ-026 Master 1 issues 4 reads, slave returns data 0xA5A5..0xA5A8 at 3-cycle latency -> m_readdatavalid[1] pulses 4 times in order, other masters see none.
REQ-027 5 reads issued with no return -> 5th held (m_waitrequest[g]=1, s_read_n=1) until first readdatavalid, then accepted that cycle.
REQ-028 s_readdatavalid pulsed with no pending read -> no m_readdatavalid pulse, err_rdv=1 and held.
REQ-029 rst asserted with 2 reads pending mid-grant -> grant=0, FIFO empty; subsequent returns set err_rdv.
REQ-030 SRAM_ARB_PRIORITY_EN defined, masters 0 and 1 requesting continuously -> master 0 granted on every ARB_IDLE arbitration.
